// File: rtl/dmem_arbiter.sv
// Two-port (core LSU / debug-DMA) arbiter in front of a single-ported data memory.
// Handles byte/half/word accesses, read-modify-write for sub-word stores, and alignment/range errors.
module dmem_arbiter #(
    parameter int MEM_BYTES = 64
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [1:0]  a_size,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_ack,
    output logic [31:0] a_rdata,
    output logic        a_err,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [1:0]  b_size,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_ack,
    output logic [31:0] b_rdata,
    output logic        b_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    // state | meaning
    // IDLE  | waiting for a request, arbitrates A vs B
    // RD    | memory read (load, or first half of a sub-word store)
    // WR    | memory write (word store, or merged sub-word store)
    // RESP  | one-cycle ack to the granted port
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_BYTES - 4);

    state_t      state;
    logic        last_b;
    logic        gnt_b;
    logic        we_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        sel_b;
    logic        sel_we;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_err;

    function automatic logic access_err(input logic [1:0] size, input logic [31:0] addr);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = addr[0];
            2'b10:   bad = (addr[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad || ({addr[31:2], 2'b00} > ADDR_LIMIT);
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                            input logic [1:0] lane);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (size)
            2'b00:   return {24'h0, sh[7:0]};
            2'b01:   return {16'h0, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] word, input logic [31:0] wdata,
                                          input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] m;
        m = word;
        case (size)
            2'b00:   m[{lane, 3'b000} +: 8] = wdata[7:0];
            2'b01:   m[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: m = wdata;
        endcase
        return m;
    endfunction

    // The tie pointer only moves on contended grants, so consecutive ties alternate winners.
    always_comb begin
        sel_b     = b_req && (!a_req || !last_b);
        sel_we    = sel_b ? b_we    : a_we;
        sel_size  = sel_b ? b_size  : a_size;
        sel_addr  = sel_b ? b_addr  : a_addr;
        sel_wdata = sel_b ? b_wdata : a_wdata;
        sel_err   = access_err(sel_size, sel_addr);
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state     <= IDLE;
            last_b    <= 1'b1;
            gnt_b     <= 1'b0;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            a_ack     <= 1'b0;
            a_err     <= 1'b0;
            a_rdata   <= 32'h0;
            b_ack     <= 1'b0;
            b_err     <= 1'b0;
            b_rdata   <= 32'h0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
        end else begin
            a_ack     <= 1'b0;
            a_err     <= 1'b0;
            a_rdata   <= 32'h0;
            b_ack     <= 1'b0;
            b_err     <= 1'b0;
            b_rdata   <= 32'h0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        gnt_b   <= sel_b;
                        we_q    <= sel_we;
                        size_q  <= sel_size;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        if (a_req && b_req) last_b <= sel_b;
                        if (sel_err) begin
                            state <= RESP;
                            if (sel_b) begin
                                b_ack <= 1'b1;
                                b_err <= 1'b1;
                            end else begin
                                a_ack <= 1'b1;
                                a_err <= 1'b1;
                            end
                        end else if (!sel_we || sel_size != 2'b10) begin
                            state    <= RD;
                            mem_read <= 1'b1;
                            mem_addr <= {sel_addr[31:2], 2'b00};
                        end else begin
                            state     <= WR;
                            mem_write <= 1'b1;
                            mem_addr  <= {sel_addr[31:2], 2'b00};
                            mem_wdata <= sel_wdata;
                        end
                    end
                end
                RD: begin
                    if (!we_q) begin
                        state <= RESP;
                        if (gnt_b) begin
                            b_ack   <= 1'b1;
                            b_rdata <= extract(mem_rdata, size_q, addr_q[1:0]);
                        end else begin
                            a_ack   <= 1'b1;
                            a_rdata <= extract(mem_rdata, size_q, addr_q[1:0]);
                        end
                    end else begin
                        state     <= WR;
                        mem_write <= 1'b1;
                        mem_addr  <= {addr_q[31:2], 2'b00};
                        mem_wdata <= merge(mem_rdata, wdata_q, size_q, addr_q[1:0]);
                    end
                end
                WR: begin
                    state <= RESP;
                    if (gnt_b) b_ack <= 1'b1;
                    else       a_ack <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed transactions push expected acks and memory
// accesses into queues; a negedge monitor pops and compares them as the DUT presents them.
module tb_dmem_arbiter;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [1:0]  a_size = 2'b00, b_size = 2'b00;
    logic [31:0] a_addr = 32'h0, a_wdata = 32'h0, b_addr = 32'h0, b_wdata = 32'h0;
    logic        a_ack, a_err, b_ack, b_err, mem_read, mem_write;
    logic [31:0] a_rdata, b_rdata, mem_addr, mem_wdata, mem_rdata;

    always #5 Clk = ~Clk;

    dmem_arbiter #(.MEM_BYTES(64)) dut (
        .Clk(Clk), .Rst(Rst),
        .a_req(a_req), .a_we(a_we), .a_size(a_size), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_size(b_size), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    // data memory model, preloaded while init_mem is high
    logic [31:0] mem [0:15];
    logic        init_mem = 1'b1;
    assign mem_rdata = mem_read ? mem[mem_addr[5:2]] : 32'h0;
    always @(posedge Clk) begin
        if (init_mem) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[2] <= 32'h11223344;
            mem[3] <= 32'hCAFEF00D;
        end else if (mem_write) begin
            mem[mem_addr[5:2]] <= mem_wdata;
        end
    end

    typedef struct { bit port; bit err; logic [31:0] rdata; } rsp_t;
    typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; } acc_t;
    rsp_t rsp_q[$];
    acc_t acc_q[$];
    rsp_t mon_r;
    acc_t mon_m;

    int  n_chk = 0;
    int  n_fail = 0;
    bit  mon_en = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void fail_now(string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event not expected / not seen (t=%0t)", name, $time);
    endfunction

    function automatic void exp_rsp(bit port, bit err, logic [31:0] rdata);
        rsp_t r;
        r.port = port; r.err = err; r.rdata = rdata;
        rsp_q.push_back(r);
    endfunction

    function automatic void exp_acc(bit wr, logic [31:0] addr, logic [31:0] data);
        acc_t m;
        m.wr = wr; m.addr = addr; m.data = data;
        acc_q.push_back(m);
    endfunction

    always @(negedge Clk) begin
        if (mon_en) begin
            if (a_ack || b_ack) begin
                chk("ack_overlap", {31'h0, a_ack & b_ack}, 32'h0);
                if (rsp_q.size() == 0) begin
                    fail_now("unexpected_ack");
                end else begin
                    mon_r = rsp_q.pop_front();
                    chk("ack_port", {31'h0, b_ack}, {31'h0, mon_r.port});
                    chk("ack_err", {31'h0, b_ack ? b_err : a_err}, {31'h0, mon_r.err});
                    chk("ack_rdata", b_ack ? b_rdata : a_rdata, mon_r.rdata);
                end
            end
            if (!a_ack) chk("a_quiet", a_rdata | {31'h0, a_err}, 32'h0);
            if (!b_ack) chk("b_quiet", b_rdata | {31'h0, b_err}, 32'h0);
            if (mem_read || mem_write) begin
                chk("mem_rw_excl", {31'h0, mem_read & mem_write}, 32'h0);
                if (acc_q.size() == 0) begin
                    fail_now("unexpected_mem_access");
                end else begin
                    mon_m = acc_q.pop_front();
                    chk("mem_kind", {31'h0, mem_write}, {31'h0, mon_m.wr});
                    chk("mem_addr", mem_addr, mon_m.addr);
                    if (mon_m.wr) chk("mem_wdata", mem_wdata, mon_m.data);
                end
            end else begin
                chk("mem_idle", mem_addr | mem_wdata, 32'h0);
            end
        end
    end

    task automatic xact(input bit port, input bit we, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata, input int exp_lat);
        bit got;
        int lat;
        @(posedge Clk); #1;
        if (port) begin
            b_we = we; b_size = size; b_addr = addr; b_wdata = wdata; b_req = 1'b1;
        end else begin
            a_we = we; a_size = size; a_addr = addr; a_wdata = wdata; a_req = 1'b1;
        end
        @(posedge Clk);
        got = 1'b0;
        lat = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge Clk);
            lat++;
            got = port ? b_ack : a_ack;
        end
        if (!got) fail_now("ack_timeout");
        else if (exp_lat > 0) chk("latency", 32'(lat), 32'(exp_lat));
        @(posedge Clk); #1;
        if (port) b_req = 1'b0;
        else      a_req = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge Clk);
        mon_en = 1'b1;
        @(negedge Clk);
        chk("rst_acks", {30'h0, a_ack, b_ack}, 32'h0);
        chk("rst_errs", {30'h0, a_err, b_err}, 32'h0);
        chk("rst_rdata", a_rdata | b_rdata, 32'h0);
        chk("rst_mem_en", {30'h0, mem_read, mem_write}, 32'h0);
        @(posedge Clk); #1;
        Rst = 1'b1;
        init_mem = 1'b0;

        // word load
        exp_acc(0, 32'h08, 32'h0);
        exp_rsp(0, 0, 32'h11223344);
        xact(0, 0, 2'b10, 32'h08, 32'h0, 2);

        // two rounds of simultaneous loads: A,B then B,A
        exp_acc(0, 32'h08, 32'h0); exp_rsp(0, 0, 32'h11223344);
        exp_acc(0, 32'h0C, 32'h0); exp_rsp(1, 0, 32'hCAFEF00D);
        exp_acc(0, 32'h0C, 32'h0); exp_rsp(1, 0, 32'hCAFEF00D);
        exp_acc(0, 32'h08, 32'h0); exp_rsp(0, 0, 32'h11223344);
        fork
            xact(0, 0, 2'b10, 32'h08, 32'h0, 0);
            xact(1, 0, 2'b10, 32'h0C, 32'h0, 0);
        join
        fork
            xact(0, 0, 2'b10, 32'h08, 32'h0, 0);
            xact(1, 0, 2'b10, 32'h0C, 32'h0, 0);
        join

        // sub-word stores via read-modify-write
        exp_acc(0, 32'h08, 32'h0);
        exp_acc(1, 32'h08, 32'h1122AB44);
        exp_rsp(1, 0, 32'h0);
        xact(1, 1, 2'b00, 32'h09, 32'h000000AB, 3);
        chk("mem_after_byte_store", mem[2], 32'h1122AB44);

        exp_acc(0, 32'h0C, 32'h0);
        exp_acc(1, 32'h0C, 32'h5566F00D);
        exp_rsp(1, 0, 32'h0);
        xact(1, 1, 2'b01, 32'h0E, 32'hFFFF5566, 3);

        // sub-word loads
        exp_acc(0, 32'h08, 32'h0); exp_rsp(0, 0, 32'h00000022);
        xact(0, 0, 2'b00, 32'h0A, 32'h0, 2);
        exp_acc(0, 32'h08, 32'h0); exp_rsp(0, 0, 32'h000000AB);
        xact(0, 0, 2'b00, 32'h09, 32'h0, 2);
        exp_acc(0, 32'h08, 32'h0); exp_rsp(0, 0, 32'h00001122);
        xact(0, 0, 2'b01, 32'h0A, 32'h0, 2);
        exp_acc(0, 32'h0C, 32'h0); exp_rsp(1, 0, 32'h5566F00D);
        xact(1, 0, 2'b10, 32'h0C, 32'h0, 2);

        // errors: misaligned half, illegal size
        exp_rsp(0, 1, 32'h0);
        xact(0, 0, 2'b01, 32'h0B, 32'h0, 1);
        exp_rsp(1, 1, 32'h0);
        xact(1, 0, 2'b11, 32'h00, 32'h0, 1);

        // range boundary: last word commits, next word errors
        exp_acc(1, 32'h3C, 32'hDEADBEEF); exp_rsp(0, 0, 32'h0);
        xact(0, 1, 2'b10, 32'h3C, 32'hDEADBEEF, 2);
        exp_rsp(0, 1, 32'h0);
        xact(0, 1, 2'b10, 32'h40, 32'h12345678, 1);
        exp_acc(0, 32'h3C, 32'h0); exp_rsp(0, 0, 32'hDEADBEEF);
        xact(0, 0, 2'b10, 32'h3C, 32'h0, 2);

        // reset during the RD cycle aborts the load
        exp_acc(0, 32'h08, 32'h0);
        @(posedge Clk); #1;
        a_we = 1'b0; a_size = 2'b10; a_addr = 32'h08; a_req = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        @(negedge Clk);
        chk("abort_rd_active", {31'h0, mem_read}, 32'h1);
        @(posedge Clk); #1;
        a_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("abort_no_ack", {31'h0, a_ack}, 32'h0);
            chk("abort_no_read", {31'h0, mem_read}, 32'h0);
        end
        @(posedge Clk); #1;
        Rst = 1'b1;

        exp_acc(0, 32'h08, 32'h0); exp_rsp(0, 0, 32'h1122AB44);
        xact(0, 0, 2'b10, 32'h08, 32'h0, 2);

        repeat (3) @(posedge Clk);
        chk("rsp_queue_drained", 32'(rsp_q.size()), 32'h0);
        chk("mem_queue_drained", 32'(acc_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 64, meaning the data-memory size in bytes; legal word addresses are 0..MEM_BYTES-4.
REQ-002 SHALL have port Clk  in  1  single clock; all state updates on posedge.
REQ-003 SHALL have port Rst  in  1  reset; synchronous, active-low.
REQ-004 SHALL have ports a_req/b_req  in  1  access request from port A (core LSU) / port B (debug/DMA).
REQ-005 SHALL have ports a_we/b_we  in  1  1=store, 0=load.
REQ-006 SHALL have ports a_size/b_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-007 SHALL have ports a_addr/b_addr  in  32  byte address.
REQ-008 SHALL have ports a_wdata/b_wdata  in  32  store data, LSB-justified.
REQ-009 SHALL have ports a_ack/b_ack  out  1  one-cycle completion pulse.
REQ-010 SHALL have ports a_rdata/b_rdata  out  32  load data, zero-extended; 0 whenever the matching ack is 0.
REQ-011 SHALL have ports a_err/b_err  out  1  error flag, valid only with ack.
REQ-012 SHALL have port mem_addr  out  32  word-aligned address to the data memory.
REQ-013 SHALL have port mem_wdata  out  32  word written to memory, little-endian.
REQ-014 SHALL have ports mem_read/mem_write  out  1  memory read enable / write enable (memory writes at posedge).
REQ-015 SHALL have port mem_rdata  in  32  combinational memory read data; only sampled while mem_read=1.

Function
REQ-016 SHALL implement FSM states IDLE, RD, WR, RESP; IDLE is the only state that accepts requests.
REQ-017 In IDLE with any req high, SHALL grant one port, latch its we/size/addr/wdata, and go to RESP (error), RD (load or sub-word store) or WR (word store).
REQ-018 Arbitration SHALL be round-robin: one requester wins outright; both requesting grants the port not granted last; after reset A wins the first tie.
REQ-019 Error SHALL be size=11, half with addr[0]=1, word with addr[1:0]!=0, or (addr & ~3) > MEM_BYTES-4; errors issue no memory access.
REQ-020 RD SHALL drive mem_read=1, mem_addr=addr & ~3, and capture mem_rdata; load then goes to RESP, sub-word store goes to WR.
REQ-021 On a sub-word store, RD SHALL merge wdata into the captured word: byte wdata[7:0] at lane addr[1:0]; half wdata[15:0] at bytes 2*addr[1]..+1; other bytes unchanged.
REQ-022 WR SHALL drive mem_write=1, mem_addr=aligned address and mem_wdata=wdata (word) or the merged word, then go to RESP.
REQ-023 RESP SHALL pulse the granted port's ack for exactly one cycle, with err=1 and rdata=0 on error, then return to IDLE.
REQ-024 Load rdata SHALL be word >> (8*addr[1:0]) masked to size and zero-extended; store rdata SHALL be 0.
REQ-025 Latency from the IDLE sampling cycle to the ack cycle SHALL be: error 1, load 2, word store 2, sub-word store 3 cycles.
REQ-026 Requesters SHALL hold req and fields stable until ack and drop req in the cycle after ack; a req high in IDLE after ack is a new request.
REQ-027 Outside RD/WR, mem_read, mem_write, mem_addr and mem_wdata SHALL be 0; mem_read and mem_write SHALL never both be 1.
REQ-028 The non-granted port's ack/err/rdata SHALL stay 0 for the whole transaction.

Reset
REQ-029 While Rst=0 at a posedge, SHALL go to IDLE, clear all outputs and latched fields, and set last-grant to B.
REQ-030 Reset mid-transaction SHALL abort it with no ack; a WR cycle coinciding with Rst=0 still commits at that edge; no memory access after it.

Verification
REQ-031 Rst=0 for 2 cycles then A loads word at 0x08 holding 0x11223344 -> all outputs 0 in reset; a_ack 2 cycles after sampling, a_rdata=0x11223344.
REQ-032 A and B load simultaneously, twice -> first round A then B, second round B then A; no overlapping acks.
REQ-033 B stores byte 0xAB at 0x09 over 0x11223344 -> mem_read at 0x08, then mem_write 0x1122AB44, b_ack on the 3rd cycle.
REQ-034 A loads half at 0x0B -> a_err=1, a_rdata=0 after 1 cycle, mem_read and mem_write stay 0.
REQ-035 Word store 0xDEADBEEF at 0x3C -> commits; word store at 0x40 -> err, no mem_write.
REQ-036 Rst=0 during the RD cycle of a load -> no a_ack, and mem_read=0 from the next cycle.
